// File: rtl/iob_timer_reader_pkg.sv
// Shared constants and types for the timer reader.
// Holds the timer register map, bus widths, the sequencer step encoding,
// the bus command payload and a helper that maps a step to its bus command.
package iob_timer_reader_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TS_W   = 64;

    // Timer native register map (same codes as the timer core)
    localparam logic [ADDR_W-1:0] TIMER_RESET     = 2'd0;
    localparam logic [ADDR_W-1:0] TIMER_STOP      = 2'd1;
    localparam logic [ADDR_W-1:0] TIMER_DATA_HIGH = 2'd2;
    localparam logic [ADDR_W-1:0] TIMER_DATA_LOW  = 2'd3;

    // One bus transaction per step; CLEAR is a sequence of its own
    typedef enum logic [1:0] {
        SEQ_CLEAR = 2'd0,
        SEQ_STOP  = 2'd1,
        SEQ_HIGH  = 2'd2,
        SEQ_LOW   = 2'd3
    } step_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    // Address and write data issued for a given step
    function automatic bus_cmd_t step_cmd(input step_t s);
        bus_cmd_t c;
        c.addr  = TIMER_RESET;
        c.wdata = '0;
        case (s)
            SEQ_CLEAR: begin
                c.addr  = TIMER_RESET;
                c.wdata = DATA_W'(1);
            end
            SEQ_STOP:  c.addr = TIMER_STOP;
            SEQ_HIGH:  c.addr = TIMER_DATA_HIGH;
            SEQ_LOW:   c.addr = TIMER_DATA_LOW;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/iob_timer_reader_bus.sv
// Single-transaction engine for the timer native interface.
// A launch pulse registers the command and raises bus_valid; the request is
// dropped on completion (bus_valid && bus_ready) or after TIMEOUT cycles.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   launch, cmd           start one transaction with the given addr/wdata
//   bus_valid/addr/wdata  registered request towards the timer
//   bus_rdata, bus_ready  timer response
//   done_c, timeout_c     completion / abort, same cycle as the event
//   rdata_c               read data, meaningful while done_c is high
module iob_timer_reader_bus
    import iob_timer_reader_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch,
    input  bus_cmd_t          cmd,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              done_c,
    output logic              timeout_c,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // wait_cnt is 0 in the first valid cycle, so the abort lands on the
    // TIMEOUT-th cycle of bus_valid; a late ready in that cycle still wins.
    assign done_c    = bus_valid && bus_ready;
    assign timeout_c = bus_valid && !bus_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign rdata_c   = bus_rdata;

    // Request register and per-transaction wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_valid <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            wait_cnt  <= '0;
        end else if (launch) begin
            bus_valid <= 1'b1;
            bus_addr  <= cmd.addr;
            bus_wdata <= cmd.wdata;
            wait_cnt  <= '0;
        end else if (done_c || timeout_c) begin
            bus_valid <= 1'b0;
            wait_cnt  <= '0;
        end else if (bus_valid) begin
            wait_cnt  <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iob_timer_reader.sv
// Autonomous timestamp reader for the timer native CPU interface.
// On trig it snapshots the counter (STOP write), reads HIGH then LOW and
// offers {high,low} on a valid/ready stream; on clr it writes TIMER_RESET.
// Every bus access is followed by a one-cycle gap and guarded by a timeout.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   trig, clr         snapshot / clear requests (sampled every cycle)
//   err_clr           clears the sticky timeout flag
//   bus_*             timer native interface (initiator side)
//   ts_data/valid     timestamp stream, ts_ready is the consumer accept
//   busy              a sequence is in progress
//   err               sticky bus timeout flag
//   drops             saturating count of triggers lost to a full pending slot
module iob_timer_reader
    import iob_timer_reader_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              clr,
    input  logic              err_clr,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic [TS_W-1:0]   ts_data,
    output logic              ts_valid,
    input  logic              ts_ready,
    output logic              busy,
    output logic              err,
    output logic [DROP_W-1:0] drops
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_nxt;
    step_t             step_q, step_nxt;
    logic              abort_q, abort_nxt;
    logic              clr_pend_q, clr_pend_nxt;
    logic              trig_pend_q, trig_pend_nxt;
    logic [DATA_W-1:0] high_q, high_nxt;
    logic [DATA_W-1:0] low_q, low_nxt;
    logic [TS_W-1:0]   ts_data_nxt;
    logic              ts_valid_nxt;
    logic              busy_nxt;
    logic              err_nxt;
    logic [DROP_W-1:0] drops_nxt;

    logic              start_clr_c;
    logic              start_snap_c;
    logic              launch_c;
    logic              done_c;
    logic              timeout_c;
    logic [DATA_W-1:0] rdata_c;
    bus_cmd_t          cmd_c;

    // A same-cycle request is served directly, so trig in c0 gives STOP in c1.
    // A new snapshot may only start once the previous timestamp is leaving.
    assign start_clr_c  = (state_q == ST_IDLE) && (clr_pend_q || clr);
    assign start_snap_c = (state_q == ST_IDLE) && !start_clr_c && (trig_pend_q || trig)
                          && (!ts_valid || ts_ready);
    assign launch_c     = (state_nxt == ST_REQ) && (state_q != ST_REQ);
    assign cmd_c        = step_cmd(step_nxt);

    iob_timer_reader_bus #(
        .TIMEOUT (TIMEOUT)
    ) u_bus (
        .clk       (clk),
        .rst_n     (rst_n),
        .launch    (launch_c),
        .cmd       (cmd_c),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .done_c    (done_c),
        .timeout_c (timeout_c),
        .rdata_c   (rdata_c)
    );

    // State and registered-output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= SEQ_CLEAR;
            abort_q     <= 1'b0;
            clr_pend_q  <= 1'b0;
            trig_pend_q <= 1'b0;
            high_q      <= '0;
            low_q       <= '0;
            ts_data     <= '0;
            ts_valid    <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            drops       <= '0;
        end else begin
            state_q     <= state_nxt;
            step_q      <= step_nxt;
            abort_q     <= abort_nxt;
            clr_pend_q  <= clr_pend_nxt;
            trig_pend_q <= trig_pend_nxt;
            high_q      <= high_nxt;
            low_q       <= low_nxt;
            ts_data     <= ts_data_nxt;
            ts_valid    <= ts_valid_nxt;
            busy        <= busy_nxt;
            err         <= err_nxt;
            drops       <= drops_nxt;
        end
    end

    // Sequencer next state: steps through the transactions of one sequence
    always_comb begin
        state_nxt = state_q;
        step_nxt  = step_q;
        abort_nxt = abort_q;
        case (state_q)
            ST_IDLE: begin
                abort_nxt = 1'b0;
                if (start_clr_c) begin
                    state_nxt = ST_REQ;
                    step_nxt  = SEQ_CLEAR;
                end else if (start_snap_c) begin
                    state_nxt = ST_REQ;
                    step_nxt  = SEQ_STOP;
                end
            end
            ST_REQ: begin
                if (done_c) begin
                    state_nxt = ST_GAP;
                end else if (timeout_c) begin
                    state_nxt = ST_GAP;
                    abort_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort_q) begin
                    state_nxt = ST_IDLE;
                    abort_nxt = 1'b0;
                end else begin
                    case (step_q)
                        SEQ_CLEAR: state_nxt = ST_IDLE;
                        SEQ_STOP: begin
                            state_nxt = ST_REQ;
                            step_nxt  = SEQ_HIGH;
                        end
                        SEQ_HIGH: begin
                            state_nxt = ST_REQ;
                            step_nxt  = SEQ_LOW;
                        end
                        SEQ_LOW:   state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the data and output registers
    always_comb begin
        clr_pend_nxt  = clr_pend_q || clr;
        trig_pend_nxt = trig_pend_q || trig;
        high_nxt      = high_q;
        low_nxt       = low_q;
        ts_data_nxt   = ts_data;
        ts_valid_nxt  = ts_valid;
        busy_nxt      = (state_nxt != ST_IDLE);
        err_nxt       = err;
        drops_nxt     = drops;

        // Starting consumes the pending request; a request arriving in the
        // same cycle as a consumed one refills the slot.
        if (start_clr_c) begin
            clr_pend_nxt = clr_pend_q && clr;
        end
        if (start_snap_c) begin
            trig_pend_nxt = trig_pend_q && trig;
        end else if (trig && trig_pend_q && (drops != {DROP_W{1'b1}})) begin
            drops_nxt = drops + DROP_W'(1);
        end

        if (done_c && (state_q == ST_REQ) && (step_q == SEQ_HIGH)) begin
            high_nxt = rdata_c;
        end
        if (done_c && (state_q == ST_REQ) && (step_q == SEQ_LOW)) begin
            low_nxt = rdata_c;
        end

        if (ts_valid && ts_ready) begin
            ts_valid_nxt = 1'b0;
        end
        // Commit on entry to DONE so the timestamp is visible while in DONE
        if ((state_q == ST_GAP) && (state_nxt == ST_DONE)) begin
            ts_data_nxt  = {high_q, low_q};
            ts_valid_nxt = 1'b1;
        end

        // Timeout set overrides a simultaneous clear
        if (err_clr) begin
            err_nxt = 1'b0;
        end
        if (timeout_c) begin
            err_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_iob_timer_reader.sv
// Self-checking bench for iob_timer_reader with a small timer model.
module tb_iob_timer_reader;
    import iob_timer_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trig, clr, err_clr, ts_ready;
    logic        bus_valid, bus_ready;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic [63:0] ts_data;
    logic        ts_valid, busy, err;
    logic [7:0]  drops;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_timer_reader #(.TIMEOUT(16), .DROP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .clr       (clr),
        .err_clr   (err_clr),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .ts_data   (ts_data),
        .ts_valid  (ts_valid),
        .ts_ready  (ts_ready),
        .busy      (busy),
        .err       (err),
        .drops     (drops)
    );

    // Timer model: free-running counter, STOP snapshots it, RESET clears it
    logic        stall_mode = 1'b0;
    logic        fixed_mode = 1'b0;
    logic [63:0] tcnt, tsnap;
    logic [1:0]  addr_log[$];
    logic [31:0] wdata_log[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ready <= 1'b0;
            tcnt      <= 64'd0;
            tsnap     <= 64'd0;
        end else begin
            bus_ready <= bus_valid && !stall_mode;
            tcnt      <= tcnt + 64'd1;
            if (bus_valid && bus_ready) begin
                if (bus_addr == TIMER_RESET && bus_wdata[0]) tcnt <= 64'd0;
                if (bus_addr == TIMER_STOP) tsnap <= tcnt;
                addr_log.push_back(bus_addr);
                wdata_log.push_back(bus_wdata);
            end
        end
    end

    always_comb begin
        bus_rdata = 32'd0;
        if (bus_addr == TIMER_DATA_HIGH) bus_rdata = fixed_mode ? 32'h0000_0001 : tsnap[63:32];
        if (bus_addr == TIMER_DATA_LOW)  bus_rdata = fixed_mode ? 32'hFFFF_FFF0 : tsnap[31:0];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // bus_valid must never rise while bus_ready is high
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus_valid && !prev_v) check("valid_rise_ready", 64'(bus_ready), 64'd0);
            prev_v = bus_valid;
        end
    end

    typedef struct {
        logic        trig;
        logic        clr;
        logic        v;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        busy;
        logic        tsv;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(input logic tr, input logic cl, input logic v,
                                input logic [1:0] a, input logic [31:0] wd,
                                input logic b, input logic t);
        vec_t r;
        r.trig = tr; r.clr = cl; r.v = v; r.addr = a; r.wdata = wd; r.busy = b; r.tsv = t;
        return r;
    endfunction

    task automatic apply_row(input int i);
        @(negedge clk);
        check($sformatf("row%0d_valid", i), 64'(bus_valid), 64'(vecs[i].v));
        check($sformatf("row%0d_busy", i), 64'(busy), 64'(vecs[i].busy));
        check($sformatf("row%0d_tsv", i), 64'(ts_valid), 64'(vecs[i].tsv));
        if (vecs[i].v) begin
            check($sformatf("row%0d_addr", i), 64'(bus_addr), 64'(vecs[i].addr));
            check($sformatf("row%0d_wdata", i), 64'(bus_wdata), 64'(vecs[i].wdata));
        end
        trig = vecs[i].trig;
        clr  = vecs[i].clr;
    endtask

    task automatic pulse_trig();
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
    endtask

    task automatic accept();
        @(negedge clk); ts_ready = 1'b1;
        @(negedge clk); ts_ready = 1'b0;
    endtask

    task automatic wait_tsv(input string name);
        for (int k = 0; k < 60 && !ts_valid; k++) @(negedge clk);
        check(name, 64'(ts_valid), 64'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_bus_valid"}, 64'(bus_valid), 64'd0);
        check({tag, "_bus_addr"},  64'(bus_addr),  64'd0);
        check({tag, "_bus_wdata"}, 64'(bus_wdata), 64'd0);
        check({tag, "_ts_data"},   ts_data,        64'd0);
        check({tag, "_ts_valid"},  64'(ts_valid),  64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_err"},       64'(err),       64'd0);
        check({tag, "_drops"},     64'(drops),     64'd0);
    endtask

    task automatic check_snap_log(input string tag);
        check({tag, "_log_n"}, 64'(addr_log.size()), 64'd3);
        if (addr_log.size() == 3) begin
            check({tag, "_log0"}, 64'(addr_log[0]), 64'(TIMER_STOP));
            check({tag, "_log1"}, 64'(addr_log[1]), 64'(TIMER_DATA_HIGH));
            check({tag, "_log2"}, 64'(addr_log[2]), 64'(TIMER_DATA_LOW));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] old_snap;
        int          vcnt;

        // SNAP with trig in c0 (rows 0-11)
        vecs[0]  = mk(1, 0, 0, TIMER_RESET, 32'd0, 0, 0);
        vecs[1]  = mk(0, 0, 1, TIMER_STOP, 32'd0, 1, 0);
        vecs[2]  = mk(0, 0, 1, TIMER_STOP, 32'd0, 1, 0);
        vecs[3]  = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 0);
        vecs[4]  = mk(0, 0, 1, TIMER_DATA_HIGH, 32'd0, 1, 0);
        vecs[5]  = mk(0, 0, 1, TIMER_DATA_HIGH, 32'd0, 1, 0);
        vecs[6]  = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 0);
        vecs[7]  = mk(0, 0, 1, TIMER_DATA_LOW, 32'd0, 1, 0);
        vecs[8]  = mk(0, 0, 1, TIMER_DATA_LOW, 32'd0, 1, 0);
        vecs[9]  = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 0);
        vecs[10] = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 1);
        vecs[11] = mk(0, 0, 0, TIMER_RESET, 32'd0, 0, 1);
        // clr and trig together in c0: CLEAR then SNAP (rows 12-27)
        vecs[12] = mk(1, 1, 0, TIMER_RESET, 32'd0, 0, 0);
        vecs[13] = mk(0, 0, 1, TIMER_RESET, 32'd1, 1, 0);
        vecs[14] = mk(0, 0, 1, TIMER_RESET, 32'd1, 1, 0);
        vecs[15] = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 0);
        vecs[16] = mk(0, 0, 0, TIMER_RESET, 32'd0, 0, 0);
        vecs[17] = mk(0, 0, 1, TIMER_STOP, 32'd0, 1, 0);
        vecs[18] = mk(0, 0, 1, TIMER_STOP, 32'd0, 1, 0);
        vecs[19] = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 0);
        vecs[20] = mk(0, 0, 1, TIMER_DATA_HIGH, 32'd0, 1, 0);
        vecs[21] = mk(0, 0, 1, TIMER_DATA_HIGH, 32'd0, 1, 0);
        vecs[22] = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 0);
        vecs[23] = mk(0, 0, 1, TIMER_DATA_LOW, 32'd0, 1, 0);
        vecs[24] = mk(0, 0, 1, TIMER_DATA_LOW, 32'd0, 1, 0);
        vecs[25] = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 0);
        vecs[26] = mk(0, 0, 0, TIMER_RESET, 32'd0, 1, 1);
        vecs[27] = mk(0, 0, 0, TIMER_RESET, 32'd0, 0, 1);

        rst_n = 1'b0; trig = 1'b0; clr = 1'b0; err_clr = 1'b0; ts_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset_outs("rst_held");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outs("rst_rel");

        // Basic SNAP
        addr_log.delete(); wdata_log.delete();
        for (int i = 0; i < 12; i++) apply_row(i);
        check("snap1_ts", ts_data, tsnap);
        check("snap1_high", 64'(ts_data[63:32]), 64'd0);
        check_snap_log("snap1");

        // CLEAR + SNAP
        accept();
        addr_log.delete(); wdata_log.delete();
        for (int i = 12; i < 28; i++) apply_row(i);
        check("clr_ts", ts_data, tsnap);
        check("clr_ts_small", 64'(ts_data <= 64'd10), 64'd1);
        check("clr_log_n", 64'(addr_log.size()), 64'd4);
        if (addr_log.size() == 4) begin
            check("clr_log0_addr", 64'(addr_log[0]), 64'(TIMER_RESET));
            check("clr_log0_wdata", 64'(wdata_log[0]), 64'd1);
            check("clr_log1_addr", 64'(addr_log[1]), 64'(TIMER_STOP));
        end

        // Back-pressure: second trig pends, third is dropped
        accept();
        pulse_trig();
        repeat (2) @(negedge clk);
        trig = 1'b1; @(negedge clk); trig = 1'b0;
        @(negedge clk);
        trig = 1'b1; @(negedge clk); trig = 1'b0;
        wait_tsv("drop_first_tsv");
        old_snap = tsnap;
        check("drop_first_ts", ts_data, old_snap);
        check("drop_count", 64'(drops), 64'd1);
        repeat (5) @(negedge clk);
        check("drop_blocked_busy", 64'(busy), 64'd0);
        check("drop_hold_ts", ts_data, old_snap);
        check("drop_hold_tsv", 64'(ts_valid), 64'd1);
        @(negedge clk); ts_ready = 1'b1;
        @(negedge clk); ts_ready = 1'b0;
        check("drop_second_busy", 64'(busy), 64'd1);
        check("drop_second_tsv_clr", 64'(ts_valid), 64'd0);
        wait_tsv("drop_second_tsv");
        check("drop_second_ts", ts_data, tsnap);
        check("drop_second_new", 64'(tsnap != old_snap), 64'd1);
        check("drop_count_kept", 64'(drops), 64'd1);

        // Fixed timer words
        accept();
        fixed_mode = 1'b1;
        pulse_trig();
        wait_tsv("fixed_tsv");
        check("fixed_ts", ts_data, 64'h0000_0001_FFFF_FFF0);
        fixed_mode = 1'b0;

        // Timeout: responder never acknowledges
        accept();
        stall_mode = 1'b1;
        pulse_trig();
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus_valid) vcnt++;
            @(negedge clk);
        end
        check("to_valid_cycles", 64'(vcnt), 64'd16);
        check("to_err", 64'(err), 64'd1);
        check("to_busy", 64'(busy), 64'd0);
        check("to_no_tsv", 64'(ts_valid), 64'd0);
        stall_mode = 1'b0;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("to_err_clr", 64'(err), 64'd0);
        check("to_idle_after", 64'(busy), 64'd0);

        // Reset in the middle of the HIGH read
        pulse_trig();
        for (int k = 0; k < 20 && !(bus_valid && bus_addr == TIMER_DATA_HIGH); k++) @(negedge clk);
        check("rst_mid_reached_high", 64'(bus_valid && bus_addr == TIMER_DATA_HIGH), 64'd1);
        rst_n = 1'b0;
        #1 check_reset_outs("rst_mid");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_no_tsv", 64'(ts_valid), 64'd0);
        addr_log.delete(); wdata_log.delete();
        pulse_trig();
        wait_tsv("rst_after_tsv");
        check("rst_after_ts", ts_data, tsnap);
        check_snap_log("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
